// File: rtl/pacman_render_unit.sv
// Pac-Man board renderer: per-pixel wall and ghost hit flags plus a free-running clock divider.
// The pixel position is decoded to a board cell and an in-cell offset. The wall map is pure logic.
// Both render flags are registered, giving one cycle of latency from the inputs.
module pacman_render_unit #(
  parameter int unsigned CELL_PX     = 20,
  parameter int unsigned COLS        = 32,
  parameter int unsigned ROWS        = 24,
  parameter int unsigned GHOST_INSET = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        gameover,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [4:0]  ghost_x,
  input  logic [4:0]  ghost_y,
  output logic [31:0] divided_clocks,
  output logic        back_on,
  output logic        ghost_on
);

  localparam int unsigned XW       = 10;
  localparam int unsigned YW       = 9;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned BOARD_W  = COLS * CELL_PX;
  localparam int unsigned BOARD_H  = ROWS * CELL_PX;
  localparam int unsigned INSET_LO = GHOST_INSET;
  localparam int unsigned INSET_HI = CELL_PX - 1 - GHOST_INSET;

  logic [CNT_W-1:0] div_cnt;
  logic [XW-1:0]    col;
  logic [XW-1:0]    ox;
  logic [YW-1:0]    row;
  logic [YW-1:0]    oy;
  logic             on_board_c;
  logic             border_c;
  logic             pillar_c;
  logic             back_c;
  logic             ghost_cell_c;
  logic             ghost_shape_c;
  logic             ghost_c;

  // Split the pixel position into board cell and offset inside that cell
  always_comb begin
    col = x / XW'(CELL_PX);
    ox  = x % XW'(CELL_PX);
    row = y / YW'(CELL_PX);
    oy  = y % YW'(CELL_PX);
  end

  // Visible-area test; anything outside the board renders nothing
  always_comb begin
    on_board_c = (x < XW'(BOARD_W)) && (y < YW'(BOARD_H));
  end

  // Wall map: outer border ring plus pillars on every even/even cell
  always_comb begin
    border_c = (row == '0) || (row == YW'(ROWS - 1)) ||
               (col == '0) || (col == XW'(COLS - 1));
    pillar_c = ~row[0] & ~col[0];
    back_c   = on_board_c & (border_c | pillar_c);
  end

  // Ghost sprite: the inset square inside the ghost's cell, independent of walls
  always_comb begin
    ghost_cell_c  = (col == XW'(ghost_x)) && (row == YW'(ghost_y)) &&
                    (YW'(ghost_y) < YW'(ROWS));
    ghost_shape_c = (ox >= XW'(INSET_LO)) && (ox <= XW'(INSET_HI)) &&
                    (oy >= YW'(INSET_LO)) && (oy <= YW'(INSET_HI));
    ghost_c       = on_board_c & ghost_cell_c & ghost_shape_c;
  end

  // Divider counter and registered render flags, blanked during game over
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      back_on  <= 1'b0;
      ghost_on <= 1'b0;
    end else begin
      div_cnt  <= div_cnt + CNT_W'(1);
      back_on  <= back_c & ~gameover;
      ghost_on <= ghost_c & ~gameover;
    end
  end

  assign divided_clocks = div_cnt;

endmodule

// File: tb/tb_pacman_render_unit.sv
// Bench for pacman_render_unit: queued expectations checked by an independent monitor.
`timescale 1ns/1ps
module tb_pacman_render_unit;

  typedef struct {
    string       name;
    logic [31:0] div;
    bit          cb;
    bit          b;
    bit          cg;
    bit          g;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        gameover;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [4:0]  ghost_x;
  logic [4:0]  ghost_y;
  logic [31:0] divided_clocks;
  logic        back_on;
  logic        ghost_on;

  exp_t        sb[$];
  logic [31:0] model_cnt;
  int          n_tests;
  int          n_fail;

  pacman_render_unit dut (
    .CLOCK_50      (clk),
    .reset         (rst_n),
    .gameover      (gameover),
    .x             (x),
    .y             (y),
    .ghost_x       (ghost_x),
    .ghost_y       (ghost_y),
    .divided_clocks(divided_clocks),
    .back_on       (back_on),
    .ghost_on      (ghost_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference wall map for the default 32x24 board of 20-pixel cells
  function automatic bit model_back(input int xx, input int yy);
    int c;
    int r;
    c = xx / 20;
    r = yy / 20;
    if (xx >= 640 || yy >= 480) return 1'b0;
    return (r == 0) || (r == 23) || (c == 0) || (c == 31) || ((r % 2 == 0) && (c % 2 == 0));
  endfunction

  // Drive one pixel at the falling edge and queue what the next rising edge must produce
  task automatic step(input string nm, input int xx, input int yy, input int gx, input int gy,
                      input bit go, input bit cb, input bit b, input bit cg, input bit g);
    exp_t e;
    @(negedge clk);
    x         = 10'(xx);
    y         = 9'(yy);
    ghost_x   = 5'(gx);
    ghost_y   = 5'(gy);
    gameover  = go;
    model_cnt = model_cnt + 32'd1;
    e.name = nm;
    e.div  = model_cnt;
    e.cb   = cb;
    e.b    = b;
    e.cg   = cg;
    e.g    = g;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge, retire queued expectations against the outputs
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "_div"}, divided_clocks, e.div);
      if (e.cb) check({e.name, "_back"}, {31'b0, back_on}, {31'b0, e.b});
      if (e.cg) check({e.name, "_ghost"}, {31'b0, ghost_on}, {31'b0, e.g});
    end
  end

  // Watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    model_cnt = 32'd0;
    rst_n     = 1'b1;
    gameover  = 1'b0;
    x         = 10'd5;
    y         = 9'd5;
    ghost_x   = 5'd0;
    ghost_y   = 5'd0;

    // Reset asserted: outputs cleared immediately and held through clocks
    #2 rst_n = 1'b0;
    #1;
    check("rst_div", divided_clocks, 32'd0);
    check("rst_back", {31'b0, back_on}, 32'd0);
    check("rst_ghost", {31'b0, ghost_on}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_div", divided_clocks, 32'd0);
    check("rst_hold_back", {31'b0, back_on}, 32'd0);

    // Release reset between edges; first edge yields count 1
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Board boundary cases, ghost parked at cell (3,5)
    step("border_col0",  5,   100, 3, 5, 1'b0, 1, 1, 1, 0);
    step("corridor_1_1", 25,  25,  3, 5, 1'b0, 1, 0, 1, 0);
    step("pillar_2_2",   45,  45,  3, 5, 1'b0, 1, 1, 1, 0);
    step("corner",       639, 479, 3, 5, 1'b0, 1, 1, 1, 0);
    step("offboard",     700, 10,  3, 5, 1'b0, 1, 0, 1, 0);

    // Ghost shape at cell (3,5): pixels 60..79 x 100..119, sprite 62..77 x 102..117
    step("ghost_near",   62, 102, 3, 5, 1'b0, 1, 0, 1, 1);
    step("ghost_lmarg",  61, 110, 3, 5, 1'b0, 1, 0, 1, 0);
    step("ghost_far",    77, 117, 3, 5, 1'b0, 1, 0, 1, 1);
    step("ghost_rmarg",  78, 110, 3, 5, 1'b0, 1, 0, 1, 0);
    step("ghost_tmarg",  62, 101, 3, 5, 1'b0, 1, 0, 1, 0);
    step("ghost_bmarg",  77, 118, 3, 5, 1'b0, 1, 0, 1, 0);
    step("ghost_wcell",  70, 130, 3, 5, 1'b0, 1, 0, 1, 0);

    // Ghost over a pillar: both flags set together
    step("ghost_pillar", 45, 45, 2, 2, 1'b0, 1, 1, 1, 1);

    // Game over blanks both flags; clearing it restores them
    step("gameover_on",  5, 5, 0, 0, 1'b1, 1, 0, 1, 0);
    step("gameover_off", 5, 5, 0, 0, 1'b0, 1, 1, 1, 1);

    // Counter wrap from all-ones
    @(posedge clk);
    #2 force dut.div_cnt = 32'hFFFF_FFFF;
    #1 release dut.div_cnt;
    model_cnt = 32'hFFFF_FFFF;
    step("wrap", 25, 25, 3, 5, 1'b0, 1, 0, 1, 0);
    step("after_wrap", 5, 100, 3, 5, 1'b0, 1, 1, 1, 0);

    // Sweep with ghost row 24 (off the board): ghost never lit, walls follow the map
    for (int yy = 0; yy < 512; yy += 7) begin
      for (int xx = 0; xx < 1024; xx += 11) begin
        step("sweep", xx, yy, xx / 20, 24, 1'b0, 1, model_back(xx, yy), 1, 0);
      end
    end

    // Mid-sweep reset while back_on is high clears outputs before the next edge
    step("pre_reset", 5, 100, 3, 5, 1'b0, 1, 1, 1, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_div", divided_clocks, 32'd0);
    check("midrst_back", {31'b0, back_on}, 32'd0);
    check("midrst_ghost", {31'b0, ghost_on}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_cnt = 32'd0;
    step("post_reset", 62, 102, 3, 5, 1'b0, 1, 0, 1, 1);
    step("post_reset2", 45, 45, 3, 5, 1'b0, 1, 1, 1, 0);

    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
